inst_decode: RTL and testbench
==============================

INST_DECODE -- requirements
Module: inst_decode

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 inst / inst_valid / pc_in  in  32 / 1 / 10  fetched word, its valid flag, its word-index PC.
REQ-004 stall / flush  in  1 / 1  hold ID/EX register / load a bubble.
REQ-005 wb_en / wb_addr / wb_data  in  1 / 5 / 32  register-file write port from write-back.
REQ-006 id_valid / id_pc / illegal  out  1 / 10 / 1  registered valid, PC, unsupported-opcode flag.
REQ-007 rs_data / rt_data / imm_ext  out  32 each  registered operands and extended immediate.
REQ-008 dst_reg / shamt / jump_addr  out  5 / 5 / 10  destination register, shift amount, inst[9:0].
REQ-009 alu_op / alu_src  out  3 / 1  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL, 6 SRL, 7 LUI; alu_src 1 selects imm_ext.
REQ-010 reg_write / mem_read / mem_write / mem_to_reg / branch / branch_ne / jump / link  out  1 each  registered control bits.

Function
REQ-011 Register file: 32 x 32 bits; r0 reads 0 always; writes to r0 ignored.
REQ-012 Write: on posedge clk with wb_en=1 and rst=0, regs[wb_addr] <= wb_data, regardless of stall/flush.
REQ-013 Read: combinational on inst[25:21] (rs) and inst[20:16] (rt); write-read bypass when wb_en=1, wb_addr==index, index!=0 -> wb_data.
REQ-014 ID/EX register priority per edge: rst > flush > stall > load.
REQ-015 flush=1, or load with inst_valid=0: bubble (id_valid=0, every control bit and illegal =0; data outputs 0).
REQ-016 stall=1 (flush=0): all outputs hold previous value.
REQ-017 Load: outputs reflect inst/pc_in decoded in the same cycle; latency exactly 1 cycle.
REQ-018 R-type (op 0x00): funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x00 SLL, 0x02 SRL; reg_write=1, dst_reg=rd, alu_src=0, shamt=inst[10:6].
REQ-019 addi 0x08 ADD, slti 0x0A SLT: sign-extend imm; andi 0x0C AND, ori 0x0D OR: zero-extend; lui 0x0F LUI with imm_ext={imm,16'h0}; all reg_write=1, dst_reg=rt, alu_src=1.
REQ-020 lw 0x23: ADD, alu_src=1, sign-extend, mem_read=1, mem_to_reg=1, reg_write=1, dst_reg=rt.
REQ-021 sw 0x2B: ADD, alu_src=1, sign-extend, mem_write=1, reg_write=0.
REQ-022 beq 0x04 / bne 0x05: SUB, alu_src=0, branch=1, branch_ne=(op==0x05), imm_ext sign-extended word offset.
REQ-023 j 0x02: jump=1; jal 0x03: jump=1, link=1, reg_write=1, dst_reg=31.
REQ-024 Any other opcode or R-type funct: illegal=1, id_valid=1, all other control bits 0 (executes as NOP).
REQ-025 shamt=0 for non-shift instructions; jump_addr=inst[9:0] for every loaded instruction.
REQ-026 inst 0x00000000 (sll r0,r0,0) decodes as legal; reg_write=1 to r0 has no architectural effect.

Reset
REQ-027 On rst=1 at posedge clk: all 32 registers <= 0, all outputs <= 0 (id_valid=0); a simultaneous wb_en write is discarded.
REQ-028 Reset mid-stall or mid-flush: reset wins; first non-reset edge resumes normal priority.

Verification
REQ-029 rst 1 cycle, then inst=0x8C080004 (lw r8,4(r0)), valid -> next cycle id_valid=1, mem_read=1, mem_to_reg=1, dst_reg=8, imm_ext=4, rs_data=0.
REQ-030 wb_en=1, wb_addr=9, wb_data=0xDEADBEEF same cycle as inst=0x01295020 (add r10,r9,r9) -> rs_data=rt_data=0xDEADBEEF (bypass), alu_op=0, dst_reg=10.
REQ-031 wb_addr=0, wb_data=0x12345678, then read r0 -> rs_data=0.
REQ-032 inst=0x2008FFFF (addi) -> imm_ext=0xFFFFFFFF; inst=0x3408FFFF (ori) -> imm_ext=0x0000FFFF; inst=0x3C081234 (lui) -> imm_ext=0x12340000, alu_op=7.
REQ-033 stall=1 for 3 cycles with changing inst -> outputs frozen; flush=1 with stall=1 -> id_valid=0 next cycle; wb write during stall visible afterwards.
REQ-034 inst=0xFC000000 -> illegal=1, id_valid=1, reg_write=mem_write=0; inst=0x0C000123 (jal) -> jump=1, link=1, dst_reg=31, jump_addr=0x123.

Source files
------------

// File: rtl/inst_decode.sv
// Decode stage: 32x32 register file with write-back bypass, instruction decoder
// and the ID/EX pipeline register (rst > flush > stall > load).
module inst_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  input  logic [9:0]  pc_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        id_valid,
  output logic [9:0]  id_pc,
  output logic        illegal,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] imm_ext,
  output logic [4:0]  dst_reg,
  output logic [4:0]  shamt,
  output logic [9:0]  jump_addr,
  output logic [2:0]  alu_op,
  output logic        alu_src,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        branch,
  output logic        branch_ne,
  output logic        jump,
  output logic        link
);

  typedef struct packed {
    logic        valid;
    logic [9:0]  pc;
    logic        illegal;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  dst;
    logic [4:0]  shamt;
    logic [9:0]  jaddr;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic        branch_ne;
    logic        jump;
    logic        link;
  } idex_t;

  logic [31:0] regs_q [32];
  idex_t       idex_q, idex_d;

  logic [5:0]  op, funct;
  logic [4:0]  rs_idx, rt_idx, rd_idx;

  assign op     = inst[31:26];
  assign rs_idx = inst[25:21];
  assign rt_idx = inst[20:16];
  assign rd_idx = inst[15:11];
  assign funct  = inst[5:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    idex_d          = '0;
    idex_d.valid    = 1'b1;
    idex_d.pc       = pc_in;
    idex_d.jaddr    = inst[9:0];
    idex_d.imm      = {{16{inst[15]}}, inst[15:0]};
    // Same-cycle write-back is forwarded so the decoder never reads a stale value.
    if (rs_idx == 5'd0)                     idex_d.rs = '0;
    else if (wb_en && wb_addr == rs_idx)    idex_d.rs = wb_data;
    else                                    idex_d.rs = regs_q[rs_idx];
    if (rt_idx == 5'd0)                     idex_d.rt = '0;
    else if (wb_en && wb_addr == rt_idx)    idex_d.rt = wb_data;
    else                                    idex_d.rt = regs_q[rt_idx];

    case (op)
      6'h00: begin
        idex_d.reg_write = 1'b1;
        idex_d.dst       = rd_idx;
        case (funct)
          6'h20: idex_d.alu_op = 3'd0;
          6'h22: idex_d.alu_op = 3'd1;
          6'h24: idex_d.alu_op = 3'd2;
          6'h25: idex_d.alu_op = 3'd3;
          6'h2A: idex_d.alu_op = 3'd4;
          6'h00: begin idex_d.alu_op = 3'd5; idex_d.shamt = inst[10:6]; end
          6'h02: begin idex_d.alu_op = 3'd6; idex_d.shamt = inst[10:6]; end
          default: begin
            idex_d.illegal   = 1'b1;
            idex_d.reg_write = 1'b0;
            idex_d.dst       = '0;
          end
        endcase
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: begin
        idex_d.reg_write = 1'b1;
        idex_d.dst       = rt_idx;
        idex_d.alu_src   = 1'b1;
        case (op)
          6'h0A:   idex_d.alu_op = 3'd4;
          6'h0C:   begin idex_d.alu_op = 3'd2; idex_d.imm = {16'h0, inst[15:0]}; end
          6'h0D:   begin idex_d.alu_op = 3'd3; idex_d.imm = {16'h0, inst[15:0]}; end
          6'h0F:   begin idex_d.alu_op = 3'd7; idex_d.imm = {inst[15:0], 16'h0}; end
          default: idex_d.alu_op = 3'd0;
        endcase
      end
      6'h23: begin
        idex_d.alu_src    = 1'b1;
        idex_d.mem_read   = 1'b1;
        idex_d.mem_to_reg = 1'b1;
        idex_d.reg_write  = 1'b1;
        idex_d.dst        = rt_idx;
      end
      6'h2B: begin
        idex_d.alu_src   = 1'b1;
        idex_d.mem_write = 1'b1;
      end
      6'h04, 6'h05: begin
        idex_d.alu_op    = 3'd1;
        idex_d.branch    = 1'b1;
        idex_d.branch_ne = (op == 6'h05);
      end
      6'h02: idex_d.jump = 1'b1;
      6'h03: begin
        idex_d.jump      = 1'b1;
        idex_d.link      = 1'b1;
        idex_d.reg_write = 1'b1;
        idex_d.dst       = 5'd31;
      end
      default: idex_d.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush)     idex_q <= '0;
    else if (stall)       idex_q <= idex_q;
    else if (!inst_valid) idex_q <= '0;
    else                  idex_q <= idex_d;
  end

  assign id_valid   = idex_q.valid;
  assign id_pc      = idex_q.pc;
  assign illegal    = idex_q.illegal;
  assign rs_data    = idex_q.rs;
  assign rt_data    = idex_q.rt;
  assign imm_ext    = idex_q.imm;
  assign dst_reg    = idex_q.dst;
  assign shamt      = idex_q.shamt;
  assign jump_addr  = idex_q.jaddr;
  assign alu_op     = idex_q.alu_op;
  assign alu_src    = idex_q.alu_src;
  assign reg_write  = idex_q.reg_write;
  assign mem_read   = idex_q.mem_read;
  assign mem_write  = idex_q.mem_write;
  assign mem_to_reg = idex_q.mem_to_reg;
  assign branch     = idex_q.branch;
  assign branch_ne  = idex_q.branch_ne;
  assign jump       = idex_q.jump;
  assign link       = idex_q.link;

endmodule

// File: tb/tb_inst_decode.sv
// Scoreboard bench for inst_decode: directed vectors push hand-computed
// expected ID/EX contents; a monitor compares one entry after each clock edge.
module tb_inst_decode;

  logic        clk = 1'b0;
  logic        rst, inst_valid, stall, flush, wb_en;
  logic [31:0] inst, wb_data;
  logic [9:0]  pc_in;
  logic [4:0]  wb_addr;
  logic        id_valid, illegal, alu_src, reg_write, mem_read, mem_write;
  logic        mem_to_reg, branch, branch_ne, jump, link;
  logic [9:0]  id_pc, jump_addr;
  logic [31:0] rs_data, rt_data, imm_ext;
  logic [4:0]  dst_reg, shamt;
  logic [2:0]  alu_op;

  always #5 clk = ~clk;

  inst_decode dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .pc_in(pc_in),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc(id_pc), .illegal(illegal), .rs_data(rs_data),
    .rt_data(rt_data), .imm_ext(imm_ext), .dst_reg(dst_reg), .shamt(shamt),
    .jump_addr(jump_addr), .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .branch(branch), .branch_ne(branch_ne), .jump(jump), .link(link)
  );

  // {valid, pc, illegal, rs, rt, imm, dst, shamt, jaddr, alu_op, alu_src,
  //  ctrl = {reg_write, mem_read, mem_write, mem_to_reg, branch, branch_ne, jump, link}}
  typedef logic [139:0] out_t;
  typedef struct { out_t e; string name; } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  out_t last_exp;

  function automatic out_t mk(input logic v, input logic [9:0] pc, input logic ill,
                              input logic [31:0] rs, input logic [31:0] rt,
                              input logic [31:0] imm, input logic [4:0] dst,
                              input logic [4:0] sh, input logic [9:0] ja,
                              input logic [2:0] op, input logic src, input logic [7:0] ctrl);
    return {v, pc, ill, rs, rt, imm, dst, sh, ja, op, src, ctrl};
  endfunction

  task automatic vec(input string name, input logic r, input logic [31:0] in,
                     input logic iv, input logic [9:0] pc, input logic st,
                     input logic fl, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input out_t e);
    exp_t x;
    @(negedge clk);
    rst = r; inst = in; inst_valid = iv; pc_in = pc; stall = st; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    x.e = e; x.name = name;
    q.push_back(x);
    last_exp = e;
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t x;
      out_t got;
      x = q.pop_front();
      got = {id_valid, id_pc, illegal, rs_data, rt_data, imm_ext, dst_reg, shamt,
             jump_addr, alu_op, alu_src,
             {reg_write, mem_read, mem_write, mem_to_reg, branch, branch_ne, jump, link}};
      checks++;
      if (got !== x.e) begin
        errors++;
        $display("FAIL %s got %h expected %h", x.name, got, x.e);
      end
    end
  end

  localparam out_t ZERO = '0;

  initial begin
    out_t hold;
    rst = 1'b1; inst = '0; inst_valid = 1'b0; pc_in = '0; stall = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;

    vec("reset", 1, 32'h0, 0, 10'd0, 0, 0, 0, 5'd0, 32'h0, ZERO);
    vec("lw", 0, 32'h8C080004, 1, 10'd1, 0, 0, 0, 5'd0, 32'h0,
        mk(1, 10'd1, 0, 32'h0, 32'h0, 32'h4, 5'd8, 5'd0, 10'h004, 3'd0, 1, 8'b1101_0000));
    vec("add_bypass", 0, 32'h01295020, 1, 10'd2, 0, 0, 1, 5'd9, 32'hDEADBEEF,
        mk(1, 10'd2, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h5020, 5'd10, 5'd0, 10'h020, 3'd0, 0, 8'b1000_0000));
    vec("r0_bypass", 0, 32'h00095820, 1, 10'd3, 0, 0, 1, 5'd0, 32'h12345678,
        mk(1, 10'd3, 0, 32'h0, 32'hDEADBEEF, 32'h5820, 5'd11, 5'd0, 10'h020, 3'd0, 0, 8'b1000_0000));
    vec("r0_read", 0, 32'h00006025, 1, 10'd4, 0, 0, 0, 5'd0, 32'h0,
        mk(1, 10'd4, 0, 32'h0, 32'h0, 32'h6025, 5'd12, 5'd0, 10'h025, 3'd3, 0, 8'b1000_0000));
    vec("addi", 0, 32'h2008FFFF, 1, 10'd5, 0, 0, 0, 5'd0, 32'h0,
        mk(1, 10'd5, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd8, 5'd0, 10'h3FF, 3'd0, 1, 8'b1000_0000));
    vec("ori", 0, 32'h3408FFFF, 1, 10'd6, 0, 0, 0, 5'd0, 32'h0,
        mk(1, 10'd6, 0, 32'h0, 32'h0, 32'h0000FFFF, 5'd8, 5'd0, 10'h3FF, 3'd3, 1, 8'b1000_0000));
    vec("lui", 0, 32'h3C081234, 1, 10'd7, 0, 0, 0, 5'd0, 32'h0,
        mk(1, 10'd7, 0, 32'h0, 32'h0, 32'h12340000, 5'd8, 5'd0, 10'h234, 3'd7, 1, 8'b1000_0000));
    vec("sll", 0, 32'h00096900, 1, 10'd8, 0, 0, 0, 5'd0, 32'h0,
        mk(1, 10'd8, 0, 32'h0, 32'hDEADBEEF, 32'h6900, 5'd13, 5'd4, 10'h100, 3'd5, 0, 8'b1000_0000));
    vec("beq", 0, 32'h1120FFFF, 1, 10'd9, 0, 0, 0, 5'd0, 32'h0,
        mk(1, 10'd9, 0, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 10'h3FF, 3'd1, 0, 8'b0000_1000));
    vec("sw", 0, 32'hAC090008, 1, 10'd10, 0, 0, 0, 5'd0, 32'h0,
        mk(1, 10'd10, 0, 32'h0, 32'hDEADBEEF, 32'h8, 5'd0, 5'd0, 10'h008, 3'd0, 1, 8'b0010_0000));
    vec("illegal_op", 0, 32'hFC000000, 1, 10'd11, 0, 0, 0, 5'd0, 32'h0,
        mk(1, 10'd11, 1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 10'h000, 3'd0, 0, 8'b0000_0000));
    vec("jal", 0, 32'h0C000123, 1, 10'd12, 0, 0, 0, 5'd0, 32'h0,
        mk(1, 10'd12, 0, 32'h0, 32'h0, 32'h123, 5'd31, 5'd0, 10'h123, 3'd0, 0, 8'b1000_0011));
    vec("invalid_bubble", 0, 32'h8C080004, 0, 10'd12, 0, 0, 0, 5'd0, 32'h0, ZERO);
    vec("bne", 0, 32'h15290002, 1, 10'd13, 0, 0, 0, 5'd0, 32'h0,
        mk(1, 10'd13, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h2, 5'd0, 5'd0, 10'h002, 3'd1, 0, 8'b0000_1100));
    hold = last_exp;
    vec("stall1", 0, 32'h8C080004, 1, 10'd20, 1, 0, 1, 5'd5, 32'h0000CAFE, hold);
    vec("stall2", 0, 32'hFC000000, 1, 10'd21, 1, 0, 0, 5'd0, 32'h0, hold);
    vec("stall3", 0, 32'h3C081234, 1, 10'd22, 1, 0, 0, 5'd0, 32'h0, hold);
    vec("flush_over_stall", 0, 32'h3C081234, 1, 10'd22, 1, 1, 0, 5'd0, 32'h0, ZERO);
    vec("wb_after_stall", 0, 32'h00A03020, 1, 10'd14, 0, 0, 0, 5'd0, 32'h0,
        mk(1, 10'd14, 0, 32'h0000CAFE, 32'h0, 32'h3020, 5'd6, 5'd0, 10'h020, 3'd0, 0, 8'b1000_0000));
    vec("illegal_funct", 0, 32'h0000003F, 1, 10'd15, 0, 0, 0, 5'd0, 32'h0,
        mk(1, 10'd15, 1, 32'h0, 32'h0, 32'h3F, 5'd0, 5'd0, 10'h03F, 3'd0, 0, 8'b0000_0000));
    vec("reset_mid_stall", 1, 32'h01295020, 1, 10'd16, 1, 0, 1, 5'd9, 32'h1, ZERO);
    vec("regs_cleared", 0, 32'h01295020, 1, 10'd16, 0, 0, 0, 5'd0, 32'h0,
        mk(1, 10'd16, 0, 32'h0, 32'h0, 32'h5020, 5'd10, 5'd0, 10'h020, 3'd0, 0, 8'b1000_0000));
    vec("nop_sll0", 0, 32'h00000000, 1, 10'd17, 0, 0, 0, 5'd0, 32'h0,
        mk(1, 10'd17, 0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 10'h000, 3'd5, 0, 8'b1000_0000));

    @(negedge clk);
    inst_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
